// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP datapath blocks: default widths and the
// multiply-accumulate operation encoding.
package dsp_pkg;

  localparam int DSP_DATA_W = 16;
  localparam int DSP_ACC_W  = 32;
  localparam int DSP_ADDR_W = 4;

  // Operation codes as carried on the in_op port.
  typedef enum logic [1:0] {
    OP_MAC  = 2'd0,  // acc += a*b
    OP_MSU  = 2'd1,  // acc -= a*b
    OP_LOAD = 2'd2,  // acc  = a*b
    OP_CLR  = 2'd3   // acc  = 0
  } mac_op_e;

  // True for the ops that combine the old accumulator with the product and
  // can therefore overflow.
  function automatic logic op_is_arith(input mac_op_e op);
    return (op == OP_MAC) || (op == OP_MSU);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulate step: combines the old accumulator value with the
// sign-extended product according to the op, with optional saturation.
module mac_sat_add
  import dsp_pkg::*;
#(
  parameter int ACC_W = DSP_ACC_W
) (
  input  logic [ACC_W-1:0] old,
  input  logic [ACC_W-1:0] product,
  input  mac_op_e          op,
  input  logic             sat,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum;

  // One guard bit above the accumulator; overflow is a disagreement between
  // the guard bit and the accumulator sign bit. The guard bit is the true sign.
  always_comb begin
    sum      = '0;
    result   = '0;
    overflow = 1'b0;
    unique case (op)
      OP_MAC:  sum = {old[ACC_W-1], old} + {product[ACC_W-1], product};
      OP_MSU:  sum = {old[ACC_W-1], old} - {product[ACC_W-1], product};
      default: sum = '0;
    endcase
    if (op_is_arith(op)) begin
      overflow = sum[ACC_W] ^ sum[ACC_W-1];
      if (overflow && sat) begin
        result = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        result = sum[ACC_W-1:0];
      end
    end else if (op == OP_LOAD) begin
      // The product always fits the accumulator, so a load cannot overflow.
      result = product;
    end else begin
      result = '0;
    end
  end

endmodule

// File: rtl/mac_stage.sv
// Three-stage multiply-accumulate pipeline in front of an external
// accumulator file: S1 registers the operation, S2 holds the product and
// reads the file, S3 holds the result and drives the writeback.
//
// Handshake: an operation transfers when in_valid && in_ready at a rising
// edge; in_ready is simply !stall, and a stall freezes every stage at once,
// so nothing is accepted, advanced or written while it is high.
module mac_stage
  import dsp_pkg::*;
#(
  parameter int DATA_W = DSP_DATA_W,
  parameter int ACC_W  = DSP_ACC_W,
  parameter int ADDR_W = DSP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [ADDR_W-1:0] in_acc,
  input  logic              in_sat,
  input  logic              stall,
  output logic [ADDR_W-1:0] acc_rd_addr,
  input  logic [ACC_W-1:0]  acc_rd_data,
  output logic              acc_wr_en,
  output logic [ADDR_W-1:0] acc_wr_addr,
  output logic [ACC_W-1:0]  acc_wr_data,
  output logic              overflow,
  output logic              busy
);

  // S1: captured operation
  logic                     s1_valid_q, s1_valid_d;
  mac_op_e                  s1_op_q,    s1_op_d;
  logic signed [DATA_W-1:0] s1_a_q,     s1_a_d;
  logic signed [DATA_W-1:0] s1_b_q,     s1_b_d;
  logic [ADDR_W-1:0]        s1_acc_q,   s1_acc_d;
  logic                     s1_sat_q,   s1_sat_d;

  // S2: registered product
  logic                     s2_valid_q, s2_valid_d;
  mac_op_e                  s2_op_q,    s2_op_d;
  logic [ACC_W-1:0]         s2_prod_q,  s2_prod_d;
  logic [ADDR_W-1:0]        s2_acc_q,   s2_acc_d;
  logic                     s2_sat_q,   s2_sat_d;

  // S3: result awaiting writeback
  logic                     s3_valid_q,  s3_valid_d;
  logic [ADDR_W-1:0]        s3_acc_q,    s3_acc_d;
  logic [ACC_W-1:0]         s3_result_q, s3_result_d;
  logic                     s3_ovf_q,    s3_ovf_d;

  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [ACC_W-1:0]    prod_ext;
  logic                       fwd_hit;
  logic [ACC_W-1:0]           old_val;
  logic [ACC_W-1:0]           add_result;
  logic                       add_ovf;

  assign prod_full = s1_a_q * s1_b_q;
  assign prod_ext  = ACC_W'(prod_full);

  // Every op writes its accumulator, so a match against a valid S3 entry
  // means the file still holds a stale value for that index this cycle.
  assign acc_rd_addr = s2_acc_q;
  assign fwd_hit     = s3_valid_q && (s3_acc_q == s2_acc_q);
  assign old_val     = fwd_hit ? s3_result_q : acc_rd_data;

  mac_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .old      (old_val),
    .product  (s2_prod_q),
    .op       (s2_op_q),
    .sat      (s2_sat_q),
    .result   (add_result),
    .overflow (add_ovf)
  );

  // Pipeline advance: all stages move together unless stalled.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_acc_d    = s1_acc_q;
    s1_sat_d    = s1_sat_q;
    s2_valid_d  = s2_valid_q;
    s2_op_d     = s2_op_q;
    s2_prod_d   = s2_prod_q;
    s2_acc_d    = s2_acc_q;
    s2_sat_d    = s2_sat_q;
    s3_valid_d  = s3_valid_q;
    s3_acc_d    = s3_acc_q;
    s3_result_d = s3_result_q;
    s3_ovf_d    = s3_ovf_q;
    if (!stall) begin
      s1_valid_d  = in_valid;
      s1_op_d     = mac_op_e'(in_op);
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_acc_d    = in_acc;
      s1_sat_d    = in_sat;
      s2_valid_d  = s1_valid_q;
      s2_op_d     = s1_op_q;
      s2_prod_d   = prod_ext;
      s2_acc_d    = s1_acc_q;
      s2_sat_d    = s1_sat_q;
      s3_valid_d  = s2_valid_q;
      s3_acc_d    = s2_acc_q;
      s3_result_d = add_result;
      s3_ovf_d    = add_ovf;
    end
  end

  // Stage registers; reset discards every in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_MAC;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_acc_q    <= '0;
      s1_sat_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_op_q     <= OP_MAC;
      s2_prod_q   <= '0;
      s2_acc_q    <= '0;
      s2_sat_q    <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_acc_q    <= '0;
      s3_result_q <= '0;
      s3_ovf_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_acc_q    <= s1_acc_d;
      s1_sat_q    <= s1_sat_d;
      s2_valid_q  <= s2_valid_d;
      s2_op_q     <= s2_op_d;
      s2_prod_q   <= s2_prod_d;
      s2_acc_q    <= s2_acc_d;
      s2_sat_q    <= s2_sat_d;
      s3_valid_q  <= s3_valid_d;
      s3_acc_q    <= s3_acc_d;
      s3_result_q <= s3_result_d;
      s3_ovf_q    <= s3_ovf_d;
    end
  end

  assign in_ready    = !stall;
  assign acc_wr_en   = s3_valid_q && !stall;
  assign acc_wr_addr = s3_acc_q;
  assign acc_wr_data = s3_result_q;
  assign overflow    = acc_wr_en && s3_ovf_q;
  assign busy        = s1_valid_q || s2_valid_q || s3_valid_q;

endmodule

// File: tb/tb_mac_stage.sv
// Bench for mac_stage: an accumulator-file model on the write/read ports,
// a sequential reference model filling an expected queue at accept time,
// and a negedge monitor that checks every writeback against it.
module tb_mac_stage;
  import dsp_pkg::*;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int ADDR_W = 4;
  localparam int N_ACC  = 16;
  localparam int EXP_W  = ADDR_W + ACC_W + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_op = 2'd0;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic [ADDR_W-1:0] in_acc = '0;
  logic              in_sat = 1'b0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] acc_rd_addr;
  logic [ACC_W-1:0]  acc_rd_data;
  logic              acc_wr_en;
  logic [ADDR_W-1:0] acc_wr_addr;
  logic [ACC_W-1:0]  acc_wr_data;
  logic              overflow;
  logic              busy;

  // environment-side controls
  logic              env_clr = 1'b1;
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [ACC_W-1:0]  pre_data = '0;
  logic              mon_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;

  // scoreboard state
  logic [EXP_W-1:0]  exp_q[$];
  int                acc_cyc_q[$];
  int                stall_at_q[$];
  logic [ACC_W-1:0]  prev_q[$];
  logic [ACC_W-1:0]  model_acc [N_ACC];

  // observed writes, for directed scenario checks
  int                log_cyc[$];
  logic [ADDR_W-1:0] log_addr[$];
  logic [ACC_W-1:0]  log_data[$];
  logic              log_ovf[$];

  logic [ACC_W-1:0]  acc_file [N_ACC];

  mac_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_acc      (in_acc),
    .in_sat      (in_sat),
    .stall       (stall),
    .acc_rd_addr (acc_rd_addr),
    .acc_rd_data (acc_rd_data),
    .acc_wr_en   (acc_wr_en),
    .acc_wr_addr (acc_wr_addr),
    .acc_wr_data (acc_wr_data),
    .overflow    (overflow),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- accumulator file ----------------
  assign acc_rd_data = acc_file[acc_rd_addr];

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < N_ACC; i++) acc_file[i] <= '0;
    end else if (acc_wr_en) begin
      acc_file[acc_wr_addr] <= acc_wr_data;
    end else if (pre_en) begin
      acc_file[pre_addr] <= pre_data;
    end
  end

  // ---------------- reference model ----------------
  // Sequential semantics: each op sees the value left by all earlier ops.
  function automatic logic [ACC_W:0] ref_op(input logic [ACC_W-1:0] old,
                                            input logic [1:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic sat);
    longint p, s, lo, hi;
    logic ov;
    logic [ACC_W-1:0] r;
    p  = longint'($signed(a)) * longint'($signed(b));
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -(longint'(1) <<< (ACC_W - 1));
    case (op)
      2'd0:    s = longint'($signed(old)) + p;
      2'd1:    s = longint'($signed(old)) - p;
      2'd2:    s = p;
      default: s = 0;
    endcase
    ov = (op < 2'd2) && ((s > hi) || (s < lo));
    if (ov && sat) s = (s > hi) ? hi : lo;
    r = s[ACC_W-1:0];
    return {ov, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- acceptance: push expectations ----------------
  always @(posedge clk) begin
    logic [ACC_W:0]   r;
    logic [EXP_W-1:0] e;
    logic [ACC_W-1:0] pv;
    int               dummy;
    cyc++;
    if (stall) stall_cnt++;
    if (env_clr) begin
      for (int i = 0; i < N_ACC; i++) model_acc[i] = '0;
    end
    if (reset) begin
      // discarded ops never reach the file: unwind their model effects
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_back();
        pv = prev_q.pop_back();
        model_acc[e[EXP_W-1 -: ADDR_W]] = pv;
        dummy = acc_cyc_q.pop_back();
        dummy = stall_at_q.pop_back();
      end
    end else begin
      if (pre_en) model_acc[pre_addr] = pre_data;
      if (in_valid && !stall) begin
        r = ref_op(model_acc[in_acc], in_op, in_a, in_b, in_sat);
        exp_q.push_back({in_acc, r[ACC_W-1:0], r[ACC_W]});
        prev_q.push_back(model_acc[in_acc]);
        acc_cyc_q.push_back(cyc);
        stall_at_q.push_back(stall_cnt);
        model_acc[in_acc] = r[ACC_W-1:0];
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [ACC_W-1:0] pv;
    int lat;
    if (mon_en) begin
      chk("in_ready", in_ready, !stall);
      chk("busy", busy, exp_q.size() != 0);
      if (stall) chk("wr_en_during_stall", acc_wr_en, 1'b0);
      if (!acc_wr_en) chk("overflow_without_write", overflow, 1'b0);
      if (acc_wr_en) begin
        log_cyc.push_back(cyc);
        log_addr.push_back(acc_wr_addr);
        log_data.push_back(acc_wr_data);
        log_ovf.push_back(overflow);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0d data=0x%0h expected=no write", acc_wr_addr, acc_wr_data);
        end else begin
          e   = exp_q.pop_front();
          pv  = prev_q.pop_front();
          lat = (cyc - acc_cyc_q.pop_front()) - (stall_cnt - stall_at_q.pop_front());
          chk("wr_addr", acc_wr_addr, e[EXP_W-1 -: ADDR_W]);
          chk("wr_data", acc_wr_data, e[ACC_W:1]);
          chk("wr_overflow", overflow, e[0]);
          chk("wr_latency", lat, 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int a, input int b,
                       input int acc, input logic sat);
    step();
    in_valid = 1'b1;
    in_op    = op;
    in_a     = DATA_W'(a);
    in_b     = DATA_W'(b);
    in_acc   = ADDR_W'(acc);
    in_sat   = sat;
  endtask

  task automatic idle();
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_done", exp_q.size() == 0, 1'b1);
    step();
  endtask

  task automatic preload(input int idx, input logic [ACC_W-1:0] val);
    step();
    pre_en   = 1'b1;
    pre_addr = ADDR_W'(idx);
    pre_data = val;
    step();
    pre_en   = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return DATA_W'(16'h8000);
      1:       return DATA_W'(16'h7fff);
      2:       return DATA_W'($urandom_range(0, 7));
      default: return DATA_W'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int first_acc;
    logic [ACC_W-1:0] keep7;

    // reset with an op offered: it must be ignored
    in_valid = 1'b1;
    in_op    = 2'd2;
    in_a     = 16'd5;
    in_b     = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    env_clr  = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b1;
    @(negedge clk);
    chk("rst_wr_en", acc_wr_en, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_addr", acc_wr_addr, '0);
    chk("rst_wr_data", acc_wr_data, '0);
    chk("rst_in_ready_stalled", in_ready, 1'b0);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy_after", busy, 1'b0);
    mon_en = 1'b1;

    // LOAD then MAC back-to-back on acc2
    base = log_data.size();
    issue(2'd2, 3, 4, 2, 1'b0);
    first_acc = cyc + 1;
    issue(2'd0, 2, 5, 2, 1'b0);
    idle();
    drain();
    chk("b2b_count", log_data.size() - base, 2);
    chk("b2b_first", log_data[base], 32'd12);
    chk("b2b_second", log_data[base+1], 32'd22);
    chk("b2b_consecutive", log_cyc[base+1] - log_cyc[base], 1);
    chk("b2b_second_timing", log_cyc[base+1] - first_acc, 3);

    // positive overflow with and without saturation
    preload(5, 32'h7FFF_FFF0);
    base = log_data.size();
    issue(2'd0, 16, 1, 5, 1'b1);
    idle();
    drain();
    chk("sat_data", log_data[base], 32'h7FFF_FFFF);
    chk("sat_ovf", log_ovf[base], 1'b1);
    preload(5, 32'h7FFF_FFF0);
    base = log_data.size();
    issue(2'd0, 16, 1, 5, 1'b0);
    idle();
    drain();
    chk("wrap_data", log_data[base], 32'h8000_0000);
    chk("wrap_ovf", log_ovf[base], 1'b1);

    // MSU of the largest positive product from zero
    preload(1, 32'h0);
    base = log_data.size();
    issue(2'd1, -32768, -32768, 1, 1'b1);
    idle();
    drain();
    chk("msu_data", log_data[base], 32'hC000_0000);
    chk("msu_ovf", log_ovf[base], 1'b0);

    // CLR then MAC
    preload(3, 32'h1234_5678);
    base = log_data.size();
    issue(2'd3, 77, 88, 3, 1'b0);
    issue(2'd0, 1, 1, 3, 1'b0);
    idle();
    drain();
    chk("clr_data", log_data[base], 32'd0);
    chk("clr_ovf", log_ovf[base], 1'b0);
    chk("clr_mac_data", log_data[base+1], 32'd1);

    // three ops in flight, then a 3-cycle stall
    base = log_data.size();
    issue(2'd2, 7, 7, 8, 1'b0);
    issue(2'd2, -2, 3, 9, 1'b0);
    issue(2'd0, 1, 1, 8, 1'b0);
    first_acc = cyc + 1;
    step();
    in_valid = 1'b0;
    stall    = 1'b1;
    step();
    step();
    step();
    stall = 1'b0;
    drain();
    chk("stall_count", log_data.size() - base, 3);
    chk("stall_first_cycle", log_cyc[base] - first_acc, 3);
    chk("stall_addr0", log_addr[base], 4'd8);
    chk("stall_addr1", log_addr[base+1], 4'd9);
    chk("stall_data0", log_data[base], 32'd49);
    chk("stall_data1", log_data[base+1], 32'hFFFF_FFFA);
    chk("stall_data2", log_data[base+2], 32'd50);

    // reset right after accepting an op to acc7
    preload(7, 32'h0000_1234);
    keep7 = 32'h0000_1234;
    base  = log_data.size();
    issue(2'd0, 1, 1, 7, 1'b0);
    step();
    reset  = 1'b1;
    in_acc = 4'd7;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_flight_busy", busy, 1'b0);
    repeat (6) step();
    chk("rst_flight_no_write", log_data.size() - base, 0);
    chk("rst_flight_acc7", acc_file[7], keep7);

    // randomized traffic with stalls and forwarding pressure
    for (int i = 0; i < 800; i++) begin
      step();
      stall    = ($urandom_range(0, 99) < 15);
      in_valid = ($urandom_range(0, 99) < 70);
      in_op    = 2'($urandom_range(0, 3));
      in_a     = rnd_operand();
      in_b     = rnd_operand();
      in_acc   = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 2))
                                             : ADDR_W'($urandom_range(0, N_ACC - 1));
      in_sat   = 1'($urandom_range(0, 1));
    end
    step();
    in_valid = 1'b0;
    stall    = 1'b0;
    drain();
    for (int i = 0; i < N_ACC; i++) chk($sformatf("final_acc%0d", i), acc_file[i], model_acc[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
